dds_voice_bank: RTL and testbench

N-voice time-multiplexed DDS core. It generalises the fixed two-oscillator arrangement into a parameterised bank: one shared phase adder and waveform stage serve NUM_VOICES accumulators, one voice slot per clock. Per-voice tuning, waveform, pulse width and enable are written through a register port driven by the SPI command decoder. Each frame's summed mix is presented to the modulation / DAC-output path with a one-cycle valid strobe.

---
 rtl/dds_voice_bank.sv | 188 ++++++++++++++++++
 tb/tb_dds_voice_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_voice_bank.sv
`default_nettype none
// ============================================================================
// Module   : dds_voice_bank
// Purpose  : Time-multiplexed N-voice DDS. One shared phase adder and waveform
//            stage visit one voice slot per clock; each frame's summed mix is
//            presented with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module dds_voice_bank #(
   parameter  int NUM_VOICES = 4,
   parameter  int TUNE_W     = 16,
   parameter  int ACC_W      = 16,
   parameter  int WAVE_W     = 12,
   localparam int VW         = $clog2(NUM_VOICES),
   localparam int MIX_W      = WAVE_W + VW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_en,
   input  logic              cfg_we,
   input  logic [VW-1:0]     cfg_voice,
   input  logic [1:0]        cfg_field,
   input  logic [TUNE_W-1:0] cfg_data,
   output logic [MIX_W-1:0]  mix_out,
   output logic              mix_valid,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [VW-1:0]       slot;
   logic [MIX_W-1:0]    sum;
   logic [MIX_W-1:0]    sum_nxt;
   logic                last_slot;
   logic                cfg_hit;

   // Per-voice views gathered for the shared waveform stage
   logic [WAVE_W-1:0]     p_a  [NUM_VOICES];
   logic [WAVE_W-1:0]     t_a  [NUM_VOICES];
   logic [WAVE_W-1:0]     pw_a [NUM_VOICES];
   logic [1:0]            sel_a[NUM_VOICES];
   logic [NUM_VOICES-1:0] en_v;

   logic [WAVE_W-1:0]   phase_p;
   logic [WAVE_W-1:0]   phase_t;
   logic [WAVE_W-1:0]   wave;

   // Writes addressed to a non-existent voice are dropped entirely
   assign cfg_hit   = cfg_we && (32'(cfg_voice) < NUM_VOICES);
   assign last_slot = (slot == VW'(NUM_VOICES - 1));

   for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
      logic [TUNE_W-1:0] tune_q;
      logic [ACC_W-1:0]  acc_q;
      logic [WAVE_W-1:0] pw_q;
      logic [1:0]        sel_q;
      logic              en_q;
      logic              wr;
      logic              in_slot;

      assign wr      = cfg_hit && (cfg_voice == VW'(k));
      assign in_slot = (state == RUN) && (slot == VW'(k));

      // Voice configuration registers; a write in the voice's own slot
      // lands after the slot has already consumed the old value
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            tune_q <= '0;
            sel_q  <= 2'd0;
            en_q   <= 1'b0;
            pw_q   <= {1'b1, {(WAVE_W-1){1'b0}}};
         end else if (wr) begin
            case (cfg_field)
               2'd0:    tune_q <= cfg_data;
               2'd1: begin
                  sel_q <= cfg_data[1:0];
                  en_q  <= cfg_data[TUNE_W-1];
               end
               2'd2:    pw_q   <= cfg_data[WAVE_W-1:0];
               default: ;
            endcase
         end
      end

      // Phase accumulator: a phase-reset write beats the slot's advance
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            acc_q <= '0;
         else if (wr && (cfg_field == 2'd3) && cfg_data[0])
            acc_q <= '0;
         else if (in_slot && en_q)
            acc_q <= acc_q + ACC_W'(tune_q);
      end

      assign p_a[k]   = acc_q[ACC_W-1 -: WAVE_W];
      assign t_a[k]   = acc_q[ACC_W-2 -: WAVE_W];
      assign pw_a[k]  = pw_q;
      assign sel_a[k] = sel_q;
      assign en_v[k]  = en_q;
   end

   assign phase_p = p_a[slot];
   assign phase_t = t_a[slot];

   // Shared waveform generator, fed by the pre-update accumulator of the slot
   always_comb begin
      wave = '0;
      case (sel_a[slot])
         2'd0:    wave = phase_p;
         2'd1:    wave = (phase_p < pw_a[slot]) ? '1 : '0;
         2'd2:    wave = phase_p[WAVE_W-1] ? ~phase_t : phase_t;
         default: wave = '0;
      endcase
   end

   assign sum_nxt = sum + (en_v[slot] ? MIX_W'(wave) : '0);

   // Frame state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Frame sequencing and busy flag
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: if (sample_en) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_slot) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Slot counter, running sum and mix output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot      <= '0;
         sum       <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (sample_en) begin
                  slot <= '0;
                  sum  <= '0;
               end
            end
            RUN: begin
               sum  <= sum_nxt;
               slot <= slot + VW'(1);
               if (last_slot) begin
                  mix_out   <= sum_nxt;
                  mix_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky overrun; a new overrun outranks a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun <= 1'b0;
      else if (sample_en && (state != IDLE))
         overrun <= 1'b1;
      else if (cfg_hit && (cfg_field == 2'd3) && cfg_data[TUNE_W-1])
         overrun <= 1'b0;
   end

endmodule
`default_nettype wire

// File: tb/tb_dds_voice_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dds_voice_bank
// Purpose  : Directed self-checking bench for dds_voice_bank (4-voice main
//            instance plus a 3-voice instance for out-of-range writes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_voice_bank;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        sample_en, cfg_we;
   logic [1:0]  cfg_voice, cfg_field;
   logic [15:0] cfg_data;
   logic [13:0] mix_out;
   logic        mix_valid, busy, overrun;

   logic        sample_en3, cfg_we3;
   logic [1:0]  cfg_voice3, cfg_field3;
   logic [15:0] cfg_data3;
   logic [13:0] mix_out3;
   logic        mix_valid3, busy3, overrun3;

   int total = 0;
   int bad   = 0;

   logic [13:0] m;
   int          l;
   int          nvalid;

   dds_voice_bank dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .cfg_we    (cfg_we),
      .cfg_voice (cfg_voice),
      .cfg_field (cfg_field),
      .cfg_data  (cfg_data),
      .mix_out   (mix_out),
      .mix_valid (mix_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   dds_voice_bank #(.NUM_VOICES(3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en3),
      .cfg_we    (cfg_we3),
      .cfg_voice (cfg_voice3),
      .cfg_field (cfg_field3),
      .cfg_data  (cfg_data3),
      .mix_out   (mix_out3),
      .mix_valid (mix_valid3),
      .busy      (busy3),
      .overrun   (overrun3)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [1:0] v, input logic [1:0] f, input logic [15:0] d);
      cfg_we = 1'b1; cfg_voice = v; cfg_field = f; cfg_data = d;
      tick;
      cfg_we = 1'b0;
   endtask

   task automatic cfg3(input logic [1:0] v, input logic [1:0] f, input logic [15:0] d);
      cfg_we3 = 1'b1; cfg_voice3 = v; cfg_field3 = f; cfg_data3 = d;
      tick;
      cfg_we3 = 1'b0;
   endtask

   // One frame on the 4-voice instance; optional config write at the edge
   // that closes slot cs (cs < 0: none). lat = edges after acceptance.
   task automatic run_frame(input int cs, input logic [1:0] cv, input logic [1:0] cf,
                            input logic [15:0] cd, output logic [13:0] mix, output int lat);
      int found;
      found = -1;
      mix   = 'x;
      sample_en = 1'b1;
      tick;
      sample_en = 1'b0;
      for (int i = 0; i < 20 && found < 0; i++) begin
         if (i == cs) begin
            cfg_we = 1'b1; cfg_voice = cv; cfg_field = cf; cfg_data = cd;
         end
         tick;
         cfg_we = 1'b0;
         if (mix_valid === 1'b1) begin
            found = i + 1;
            mix   = mix_out;
         end
      end
      lat = found;
      tick;
   endtask

   task automatic frame_chk(input string tag, input logic [13:0] exp);
      logic [13:0] fm;
      int          fl;
      run_frame(-1, 2'd0, 2'd0, 16'h0000, fm, fl);
      check(tag, 32'(fm), 32'(exp));
      check({tag, "_lat"}, fl, 32'd4);
   endtask

   initial begin
      rst_n = 1'b0;
      sample_en = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_field = '0; cfg_data = '0;
      sample_en3 = 1'b0; cfg_we3 = 1'b0; cfg_voice3 = '0; cfg_field3 = '0; cfg_data3 = '0;
      repeat (2) tick;
      check("rst_mix",   32'(mix_out), 32'h0);
      check("rst_valid", 32'(mix_valid), 32'h0);
      check("rst_busy",  32'(busy), 32'h0);
      check("rst_ovr",   32'(overrun), 32'h0);
      rst_n = 1'b1;
      tick;

      // Saw on voice 0, tune 0x1000
      cfg(2'd0, 2'd0, 16'h1000);
      cfg(2'd0, 2'd1, 16'h8000);
      frame_chk("saw0", 14'h000);
      check("valid_pulse", 32'(mix_valid), 32'h0);
      check("idle_busy",   32'(busy), 32'h0);
      frame_chk("saw1", 14'h100);
      frame_chk("saw2", 14'h200);

      // Wrap: acc 0x2000 + 0xF000 -> 0x1000
      cfg(2'd0, 2'd3, 16'h0001);
      frame_chk("saw_r0", 14'h000);
      frame_chk("saw_r1", 14'h100);
      cfg(2'd0, 2'd0, 16'hF000);
      frame_chk("wrap_pre",  14'h200);
      frame_chk("wrap_post", 14'h100);
      cfg(2'd0, 2'd1, 16'h0000);

      // Square on voice 1, pw 0x800
      cfg(2'd1, 2'd1, 16'h8001);
      cfg(2'd1, 2'd2, 16'h0800);
      cfg(2'd1, 2'd0, 16'h7FF0);
      frame_chk("sq_acc0", 14'hFFF);
      cfg(2'd1, 2'd0, 16'h0010);
      frame_chk("sq_7ff0", 14'hFFF);
      frame_chk("sq_8000", 14'h000);
      cfg(2'd1, 2'd2, 16'h0000);
      cfg(2'd1, 2'd3, 16'h0001);
      frame_chk("sq_pw0", 14'h000);
      cfg(2'd1, 2'd1, 16'h0000);

      // Triangle on voice 2, tune 0x4000
      cfg(2'd2, 2'd1, 16'h8002);
      cfg(2'd2, 2'd0, 16'h4000);
      frame_chk("tri_0000", 14'h000);
      frame_chk("tri_4000", 14'h800);
      frame_chk("tri_8000", 14'hFFF);
      frame_chk("tri_c000", 14'h7FF);
      cfg(2'd2, 2'd1, 16'h0000);

      // Full mix: four squares with pw 0xFFF from acc 0
      for (int v = 0; v < 4; v++) begin
         cfg(2'(v), 2'd1, 16'h8001);
         cfg(2'(v), 2'd2, 16'h0FFF);
         cfg(2'(v), 2'd0, 16'h0100);
         cfg(2'(v), 2'd3, 16'h0001);
      end
      frame_chk("mix4", 14'h3FFC);
      cfg(2'd3, 2'd1, 16'h0001);
      frame_chk("mix3", 14'h2FFD);
      cfg(2'd0, 2'd1, 16'h0000);
      cfg(2'd1, 2'd1, 16'h0000);
      cfg(2'd2, 2'd1, 16'h0000);
      cfg(2'd3, 2'd1, 16'h8000);
      frame_chk("acc3_hold", 14'h010);
      cfg(2'd3, 2'd1, 16'h0000);

      // Tune write to voice 1 during its own slot
      cfg(2'd1, 2'd1, 16'h8000);
      cfg(2'd1, 2'd0, 16'h1000);
      cfg(2'd1, 2'd3, 16'h0001);
      run_frame(1, 2'd1, 2'd0, 16'h3000, m, l);
      check("col_tune0", 32'(m), 32'h000);
      frame_chk("col_tune1", 14'h100);
      frame_chk("col_tune2", 14'h400);
      cfg(2'd1, 2'd1, 16'h0000);

      // Phase reset of voice 2 during its own slot
      cfg(2'd2, 2'd1, 16'h8000);
      cfg(2'd2, 2'd0, 16'h1000);
      cfg(2'd2, 2'd3, 16'h0001);
      frame_chk("col_ph0", 14'h000);
      run_frame(2, 2'd2, 2'd3, 16'h0001, m, l);
      check("col_ph1", 32'(m), 32'h100);
      frame_chk("col_ph2", 14'h000);

      // Overrun: second request two cycles after the first
      check("ovr_pre", 32'(overrun), 32'h0);
      sample_en = 1'b1;
      tick;
      sample_en = 1'b0;
      check("busy_run", 32'(busy), 32'h1);
      tick;
      sample_en = 1'b1;
      tick;
      sample_en = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 12; i++) begin
         tick;
         if (mix_valid === 1'b1) nvalid++;
      end
      check("ovr_nvalid", nvalid, 32'd1);
      check("ovr_mix",    32'(mix_out), 32'h100);
      check("ovr_set",    32'(overrun), 32'h1);
      cfg(2'd0, 2'd3, 16'h8000);
      check("ovr_clr",    32'(overrun), 32'h0);

      // Three-voice instance: writes to index 3 must be ignored
      cfg3(2'd3, 2'd1, 16'h8001);
      cfg3(2'd3, 2'd0, 16'h1000);
      sample_en3 = 1'b1;
      tick;
      tick;
      sample_en3 = 1'b0;
      repeat (6) tick;
      check("ovr3_set", 32'(overrun3), 32'h1);
      cfg3(2'd3, 2'd3, 16'h8000);
      check("ovr3_ign", 32'(overrun3), 32'h1);
      sample_en3 = 1'b1;
      tick;
      sample_en3 = 1'b0;
      check("busy3_run", 32'(busy3), 32'h1);
      l = -1;
      m = 'x;
      for (int i = 0; i < 20 && l < 0; i++) begin
         tick;
         if (mix_valid3 === 1'b1) begin
            l = i + 1;
            m = mix_out3;
         end
      end
      tick;
      check("mix3v",     32'(m), 32'h0);
      check("mix3v_lat", l, 32'd3);
      cfg3(2'd2, 2'd3, 16'h8000);
      check("ovr3_clr", 32'(overrun3), 32'h0);

      // Reset in the middle of a frame with outputs active
      frame_chk("pre_rst", 14'h200);
      sample_en = 1'b1;
      tick;
      tick;
      sample_en = 1'b0;
      check("pre_rst_busy", 32'(busy), 32'h1);
      check("pre_rst_ovr",  32'(overrun), 32'h1);
      check("pre_rst_mix",  32'(mix_out), 32'h200);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_mix",   32'(mix_out), 32'h0);
      check("mid_rst_busy",  32'(busy), 32'h0);
      check("mid_rst_valid", 32'(mix_valid), 32'h0);
      check("mid_rst_ovr",   32'(overrun), 32'h0);
      tick;
      rst_n = 1'b1;
      tick;
      frame_chk("post_rst", 14'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
